// File: rtl/fifo_mwmr_pkg.sv
// rtl/fifo_mwmr_pkg.sv - primitive types and defaults shared by the multi-write multi-read queue
package fifo_mwmr_pkg;

    typedef logic        u1;
    typedef logic [63:0] u64;

    localparam int DEFAULT_QLEN = 16;
    localparam int DEFAULT_WNUM = 4;
    localparam int DEFAULT_RNUM = 2;

    // Width needed to hold a lane count from 0 up to and including n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lane_compact.sv
// rtl/lane_compact.sv - prefix popcount mapping each valid write lane to its slot offset
module lane_compact #(
    parameter int WNUM = 4,
    parameter int OW   = $clog2(WNUM + 1)
) (
    input  logic [WNUM-1:0]         valid,
    output logic [WNUM-1:0][OW-1:0] offset,
    output logic [OW-1:0]           total
);

    logic [OW-1:0] run;

    // Each lane's offset is the number of valid lanes below it; total is the full popcount.
    always_comb begin
        run    = '0;
        offset = '0;
        for (int k = 0; k < WNUM; k++) begin
            offset[k] = run;
            run       = run + OW'(valid[k]);
        end
        total = run;
    end

endmodule

// File: rtl/fifo_mwmr.sv
// rtl/fifo_mwmr.sv - circular queue accepting WNUM writes and offering RNUM in-order reads per cycle
module fifo_mwmr
    import fifo_mwmr_pkg::*;
#(
    parameter int  QLEN = DEFAULT_QLEN,
    parameter int  WNUM = DEFAULT_WNUM,
    parameter int  RNUM = DEFAULT_RNUM,
    parameter type TYPE = u64
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic [WNUM-1:0]               wvalid,
    input  TYPE  [WNUM-1:0]               wdata,
    output logic                          wready,
    output logic [RNUM-1:0]               rvalid,
    output TYPE  [RNUM-1:0]               rdata,
    input  logic [RNUM-1:0]               rready,
    output logic [$clog2(QLEN):0]         count,
    output logic                          empty,
    output logic                          full
);

    localparam int PW  = $clog2(QLEN);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam int OW  = count_width(WNUM);
    localparam int RW  = count_width(RNUM);

    TYPE mem [QLEN];

    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [WNUM-1:0][OW-1:0]  offset;
    logic [OW-1:0]            push_total;
    logic [OW-1:0]            push_amt;
    logic [RW-1:0]            pop_amt;
    logic                     push_en;
    logic                     gap_free;
    logic [CW1-1:0]           grown;

    lane_compact #(
        .WNUM (WNUM),
        .OW   (OW)
    ) u_lane_compact (
        .valid  (wvalid),
        .offset (offset),
        .total  (push_total)
    );

    // Room for a full-width write is judged on the registered count alone.
    assign wready   = (count <= CW'(QLEN - WNUM));
    assign empty    = (count == '0);
    assign full     = (count == CW'(QLEN));
    assign push_en  = wready && !flush;
    assign push_amt = push_en ? push_total : '0;

    genvar gi;
    generate
        for (gi = 0; gi < RNUM; gi++) begin : g_read
            assign rvalid[gi] = (count > CW'(gi));
            assign rdata[gi]  = mem[head + PW'(gi)];
        end
    endgenerate

    // Pop the leading run of lanes that are both present and accepted; stop at the first gap.
    always_comb begin
        pop_amt  = '0;
        gap_free = 1'b1;
        for (int i = 0; i < RNUM; i++) begin
            if (gap_free && rvalid[i] && rready[i]) begin
                pop_amt = pop_amt + RW'(1);
            end else begin
                gap_free = 1'b0;
            end
        end
    end

    // Payload storage: compacted lanes land at consecutive slots from tail; never reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WNUM; k++) begin
            if (push_en && wvalid[k]) begin
                mem[tail + PW'(offset[k])] <= wdata[k];
            end
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats any push or pop.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_amt);
            tail  <= tail + PW'(push_amt);
            count <= count + CW'(push_amt) - CW'(pop_amt);
        end
    end

    assign grown = {1'b0, count} + CW1'(push_amt);

    // Occupancy must stay within 0..QLEN whenever the queue is actually updating.
    assert property (@(posedge clk) disable iff (!resetn || flush)
        (grown <= CW1'(QLEN)) && (grown >= CW1'(pop_amt)));

endmodule

// File: doc/fifo_mwmr.md
FIFO_MWMR -- requirements
Module: fifo_mwmr

Interface
REQ-001 SHALL take parameters, one per line:
- QLEN, 16, queue depth; power of two, at least WNUM and at least RNUM.
- WNUM, 4, write lanes per cycle.
- RNUM, 2, read lanes per cycle.
- TYPE, u64, entry type.
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; every register updates on its rising edge.
- resetn  in  1  reset; synchronous, active-low.
- flush  in  1  discard all entries.
- wvalid  in  WNUM  per-lane write request.
- wdata  in  WNUM x TYPE  per-lane write payload.
- wready  out  1  all WNUM lanes may write this cycle.
- rvalid  out  RNUM  rvalid[i] means entry head+i is present.
- rdata  out  RNUM x TYPE  entry head+i; don't-care when rvalid[i] is 0.
- rready  in  RNUM  consumer accepts lane i.
- count  out  clog2(QLEN)+1  occupied entries.
- empty  out  1  count equals 0.
- full  out  1  count equals QLEN.

Function
REQ-003 SHALL hold head, tail and count registers; head and tail are clog2(QLEN) bits and wrap modulo QLEN.
REQ-004 SHALL drive wready = (QLEN - count >= WNUM), computed from the registered count only; pops in the same cycle do not raise wready.
REQ-005 SHALL accept writes only when wready is 1; when wready is 0, wvalid is ignored and write state does not change.
REQ-006 SHALL compact accepted lanes in ascending lane order: the k-th set wvalid bit writes slot tail+k, and tail advances by popcount(wvalid).
REQ-007 SHALL drive rvalid[i] = (count > i) and rdata[i] = entry at head+i (mod QLEN), combinationally from registers.
REQ-008 SHALL compute the pop amount as the number of leading lanes i, starting at lane 0, where rvalid[i] and rready[i] are both 1; any lane after the first gap is not consumed.
REQ-009 SHALL advance head by the pop amount, and set next count = count + pushes - pops.
REQ-010 SHALL make a written entry visible on rvalid/rdata one cycle after the write edge; there is no same-cycle bypass.
REQ-011 SHALL, on flush=1, set head=tail=count=0 at the next edge; flush overrides any write or pop in the same cycle.
REQ-012 SHALL preserve FIFO order across head and tail wrap-around, with no lost or duplicated entries.
REQ-013 SHALL flag an assertion (simulation only) if count would exceed QLEN or go below 0.

Reset
REQ-014 SHALL, while resetn=0 at a clock edge, set head=0, tail=0, count=0; the storage array is not reset.
REQ-015 SHALL present these outputs during and after reset: wready=1, rvalid=0, empty=1, full=0, count=0.
REQ-016 SHALL give resetn priority over flush, writes and pops, including a reset asserted mid-operation.

Structure
REQ-017 SHALL keep the entry payload types (commit_instr_t etc.) in commit_pkg and the primitive types (u1, u64) in common; the pointer widths are local to this module.
REQ-018 SHALL split off one sub-module, lane_compact: a combinational prefix-popcount that maps each valid lane to its write offset and outputs the total push count.
REQ-019 SHALL be instantiated by the commit stage with one instance per commit lane, replacing the single-read queue and adding backpressure toward execute.

Verification (QLEN=16, WNUM=4, RNUM=2)
REQ-020 Reset: resetn=0 for 1 cycle -> count=0, empty=1, full=0, wready=1, rvalid=2'b00.
REQ-021 Compaction: wvalid=4'b1010, wdata={D,C,B,A} -> next cycle count=2, rdata[0]=B, rdata[1]=D, rvalid=2'b11.
REQ-022 Fill: 4 consecutive full-width writes, rready=0 -> count=12 with wready=1, then count=16 with full=1 and wready=0; a fifth write is ignored and count stays 16.
REQ-023 Gap rule: count=2, rready=2'b10 -> 0 pops, count stays 2; rready=2'b11 -> 2 pops, count=0, empty=1.
REQ-024 Wrap: 40 sequential tags pushed at random widths and popped at random rready -> tags come out 0..39 in order and head wraps at least twice.
REQ-025 Flush priority: count=5, with flush=1 plus wvalid=4'b1111 and rready=2'b11 in the same cycle -> next cycle count=0 and empty=1; the following write of 1 entry gives count=1.
